audio_out_arbiter: RTL and testbench
====================================

AUDIO_OUT_ARBITER -- requirements
Module: audio_out_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, sample width per channel (two's complement).
REQ-002 Port: CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: mode  in  2  source select: 00 mic passthrough, 01 tone, 10 mix, 11 mute.
REQ-005 Port: audio_in_available  in  1  codec input FIFO holds a sample.
REQ-006 Port: left_channel_audio_in / right_channel_audio_in  in  DATA_W each  mic sample, valid while audio_in_available.
REQ-007 Port: read_audio_in  out  1  one-cycle pop of the codec input FIFO.
REQ-008 Port: tone_valid  in  1  tone source holds a sample.
REQ-009 Port: tone_left / tone_right  in  DATA_W each  tone sample, valid while tone_valid.
REQ-010 Port: tone_ready  out  1  one-cycle pop of the tone source.
REQ-011 Port: audio_out_allowed  in  1  codec output FIFO has space.
REQ-012 Port: left_channel_audio_out / right_channel_audio_out  out  DATA_W each  registered output sample.
REQ-013 Port: write_audio_out  out  1  one-cycle push to the codec output FIFO.

Function
REQ-014 FSM states: IDLE, SEND; one sample in flight at most.
REQ-015 IDLE, mode 00: when audio_in_available=1, pulse read_audio_in, latch mic pair into output registers, go to SEND.
REQ-016 IDLE, mode 01: when tone_valid=1, pulse tone_ready, latch tone pair, go to SEND; mic FIFO left untouched.
REQ-017 IDLE, mode 10: only when audio_in_available=1 and tone_valid=1, pulse read_audio_in and tone_ready in the same cycle, latch per-channel mix, go to SEND.
REQ-018 IDLE, mode 11: when audio_in_available=1, pulse read_audio_in, latch zeros, go to SEND (mic FIFO kept drained).
REQ-019 SEND: write_audio_out = audio_out_allowed, combinational; on that cycle go to IDLE; otherwise hold data and stay in SEND indefinitely.
REQ-020 read_audio_in and tone_ready are never asserted in SEND.
REQ-021 Latency: pop at cycle N, earliest push at N+1; peak throughput one sample per two cycles.
REQ-022 mode is sampled only in IDLE; a change during SEND has no effect on the sample in flight.
REQ-023 Mix arithmetic (macro undefined): sign-extend both to DATA_W+1, add, arithmetic shift right 1, truncate to DATA_W; no overflow possible.
REQ-024 Output registers change only on a pop cycle; they hold value otherwise.

Reset
REQ-025 On reset: state=IDLE; output data registers=0; read_audio_in, tone_ready, write_audio_out=0 while reset is high.
REQ-026 Reset during SEND discards the held sample; no push occurs after release until a new pop.

Configuration
REQ-027 Macro AUDIO_ARB_SAT_MIX_EN defined: mix = full sum saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; undefined: halved sum per REQ-023.

Structure
REQ-028 Shared package audio_arb_pkg holds the mode encoding constants (MODE_PASS, MODE_TONE, MODE_MIX, MODE_MUTE) and the FSM state typedef.
REQ-029 One sub-module, audio_mix_sat, implements the per-channel mix (halving or saturating variant); instantiated twice.

Verification
REQ-030 mode 00, mic L=0x00001234 available, out_allowed=1 -> read pulse one cycle, next cycle write pulse with L=0x00001234.
REQ-031 mode 01, tone valid, mic available -> tone_ready pulses, read_audio_in stays 0, output equals tone pair.
REQ-032 mode 10, mic=0x7FFFFFFF, tone=0x7FFFFFFF -> macro off: 0x7FFFFFFF; macro on: 0x7FFFFFFF saturated; mic=0x80000000, tone=0xFFFFFFFF -> off: 0xBFFFFFFF, on: 0x80000000.
REQ-033 SEND with out_allowed=0 for 10 cycles -> no write, no pops, data stable; allowed rises -> single write pulse.
REQ-034 reset asserted in SEND -> write never asserts, outputs=0; after release mode 11 with mic available -> write of zeros.

Source files
------------

// File: rtl/audio_arb_pkg.sv
// Shared definitions for the audio output arbiter: source-select encoding and FSM state type.
package audio_arb_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_TONE = 2'b01;
    localparam logic [1:0] MODE_MIX  = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/audio_out_arbiter_if.sv
// Handshake and sample bus between the codec FIFOs, the tone source and the arbiter.
interface audio_out_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        mode;
    logic              audio_in_available;
    logic [DATA_W-1:0] left_channel_audio_in;
    logic [DATA_W-1:0] right_channel_audio_in;
    logic              read_audio_in;
    logic              tone_valid;
    logic [DATA_W-1:0] tone_left;
    logic [DATA_W-1:0] tone_right;
    logic              tone_ready;
    logic              audio_out_allowed;
    logic [DATA_W-1:0] left_channel_audio_out;
    logic [DATA_W-1:0] right_channel_audio_out;
    logic              write_audio_out;

    modport master (
        output mode, audio_in_available, left_channel_audio_in, right_channel_audio_in,
        output tone_valid, tone_left, tone_right, audio_out_allowed,
        input  read_audio_in, tone_ready, left_channel_audio_out, right_channel_audio_out,
        input  write_audio_out
    );

    modport slave (
        input  mode, audio_in_available, left_channel_audio_in, right_channel_audio_in,
        input  tone_valid, tone_left, tone_right, audio_out_allowed,
        output read_audio_in, tone_ready, left_channel_audio_out, right_channel_audio_out,
        output write_audio_out
    );
endinterface

// File: rtl/audio_mix_sat.sv
// Per-channel mic+tone mix. Default: halved sum. With AUDIO_ARB_SAT_MIX_EN defined:
// full sum saturated to the signed DATA_W range.
module audio_mix_sat #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);
`ifdef AUDIO_ARB_SAT_MIX_EN
    logic [DATA_W:0] sum;

    assign sum = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};

    // The two top bits of the extended sum disagree exactly when it overflows DATA_W.
    always_comb begin
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            y_o = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            y_o = sum[DATA_W-1:0];
        end
    end
`else
    // floor((a+b)/2) == floor(a/2) + floor(b/2) + (a0 & b0); never leaves DATA_W.
    assign y_o = {a_i[DATA_W-1], a_i[DATA_W-1:1]}
               + {b_i[DATA_W-1], b_i[DATA_W-1:1]}
               + {{(DATA_W-1){1'b0}}, a_i[0] & b_i[0]};
`endif
endmodule

// File: rtl/audio_out_arbiter.sv
// Picks mic, tone, mix or muted samples and forwards one pair at a time to the codec output FIFO.
// Mix flavour selected by AUDIO_ARB_SAT_MIX_EN (see audio_mix_sat).
module audio_out_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    audio_out_arbiter_if.slave  bus
);
    import audio_arb_pkg::*;

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              mic_pop, tone_pop, out_push;

    logic [DATA_W-1:0] mic_ch  [2];
    logic [DATA_W-1:0] tone_ch [2];
    logic [DATA_W-1:0] mix_ch  [2];

    assign mic_ch[0]  = bus.left_channel_audio_in;
    assign mic_ch[1]  = bus.right_channel_audio_in;
    assign tone_ch[0] = bus.tone_left;
    assign tone_ch[1] = bus.tone_right;

    for (genvar gi = 0; gi < 2; gi++) begin : g_mix
        audio_mix_sat #(.DATA_W(DATA_W)) u_mix (
            .a_i (mic_ch[gi]),
            .b_i (tone_ch[gi]),
            .y_o (mix_ch[gi])
        );
    end

    always_comb begin
        mic_pop  = 1'b0;
        tone_pop = 1'b0;
        out_push = 1'b0;
        state_d  = state_q;
        left_d   = left_q;
        right_d  = right_q;
        case (state_q)
            IDLE: begin
                case (bus.mode)
                    MODE_PASS: if (bus.audio_in_available) begin
                        mic_pop = 1'b1;
                        left_d  = mic_ch[0];
                        right_d = mic_ch[1];
                    end
                    MODE_TONE: if (bus.tone_valid) begin
                        tone_pop = 1'b1;
                        left_d   = tone_ch[0];
                        right_d  = tone_ch[1];
                    end
                    MODE_MIX: if (bus.audio_in_available && bus.tone_valid) begin
                        mic_pop  = 1'b1;
                        tone_pop = 1'b1;
                        left_d   = mix_ch[0];
                        right_d  = mix_ch[1];
                    end
                    default: if (bus.audio_in_available) begin
                        // Mute still drains the mic FIFO so it cannot back up.
                        mic_pop = 1'b1;
                        left_d  = '0;
                        right_d = '0;
                    end
                endcase
                if (mic_pop || tone_pop) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.audio_out_allowed) begin
                    out_push = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Strobes are decoded from state; masking with reset keeps them low while reset is held.
    assign bus.read_audio_in           = mic_pop  & ~reset;
    assign bus.tone_ready              = tone_pop & ~reset;
    assign bus.write_audio_out         = out_push & ~reset;
    assign bus.left_channel_audio_out  = left_q;
    assign bus.right_channel_audio_out = right_q;
endmodule

// File: tb/tb_audio_out_arbiter.sv
// Directed bench for audio_out_arbiter with a per-cycle reference model and literal spot checks.
module tb_audio_out_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    audio_out_arbiter_if #(.DATA_W(32)) bus ();

    audio_out_arbiter #(.DATA_W(32)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_mix(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef AUDIO_ARB_SAT_MIX_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        s = s >>> 1;
`endif
        return s[31:0];
    endfunction

    // Reference model: at most one sample held; pops happen only when nothing is held.
    bit          m_busy;
    logic [31:0] m_l, m_r, n_l, n_r;
    logic        e_rd, e_tr, e_wr;

    always @(negedge clk) begin
        e_rd = 1'b0;
        e_tr = 1'b0;
        e_wr = 1'b0;
        n_l  = m_l;
        n_r  = m_r;
        if (rst) begin
            m_busy = 1'b0;
            m_l    = '0;
            m_r    = '0;
        end else if (m_busy) begin
            e_wr = bus.audio_out_allowed;
        end else begin
            case (bus.mode)
                2'b00: if (bus.audio_in_available) begin
                    e_rd = 1'b1; n_l = bus.left_channel_audio_in; n_r = bus.right_channel_audio_in;
                end
                2'b01: if (bus.tone_valid) begin
                    e_tr = 1'b1; n_l = bus.tone_left; n_r = bus.tone_right;
                end
                2'b10: if (bus.audio_in_available && bus.tone_valid) begin
                    e_rd = 1'b1; e_tr = 1'b1;
                    n_l = exp_mix(bus.left_channel_audio_in, bus.tone_left);
                    n_r = exp_mix(bus.right_channel_audio_in, bus.tone_right);
                end
                default: if (bus.audio_in_available) begin
                    e_rd = 1'b1; n_l = '0; n_r = '0;
                end
            endcase
        end
        chk("model_read",  {31'd0, bus.read_audio_in},   {31'd0, e_rd});
        chk("model_tone",  {31'd0, bus.tone_ready},      {31'd0, e_tr});
        chk("model_write", {31'd0, bus.write_audio_out}, {31'd0, e_wr});
        chk("model_left",  bus.left_channel_audio_out,   m_l);
        chk("model_right", bus.right_channel_audio_out,  m_r);
        if (!rst) begin
            if (m_busy && e_wr) begin
                m_busy = 1'b0;
            end else if (!m_busy && (e_rd || e_tr)) begin
                m_busy = 1'b1;
                m_l    = n_l;
                m_r    = n_r;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [31:0] exp_r_mix;
        checks = 0;
        errors = 0;
        m_busy = 1'b0;
        m_l = '0;
        m_r = '0;
        rst = 1'b1;
        bus.mode = 2'b00;
        bus.audio_in_available = 1'b0;
        bus.left_channel_audio_in = '0;
        bus.right_channel_audio_in = '0;
        bus.tone_valid = 1'b0;
        bus.tone_left = '0;
        bus.tone_right = '0;
        bus.audio_out_allowed = 1'b0;
        repeat (3) step();
        chk("reset_left", bus.left_channel_audio_out, 32'h0);
        chk("reset_write", {31'd0, bus.write_audio_out}, 32'h0);
        rst = 1'b0;
        step();

        // Mic passthrough
        bus.mode = 2'b00; bus.audio_out_allowed = 1'b1;
        bus.left_channel_audio_in = 32'h00001234; bus.right_channel_audio_in = 32'h00005678;
        bus.audio_in_available = 1'b1;
        settle();
        chk("pass_read", {31'd0, bus.read_audio_in}, 32'h1);
        step();
        bus.audio_in_available = 1'b0;
        settle();
        chk("pass_write", {31'd0, bus.write_audio_out}, 32'h1);
        chk("pass_left", bus.left_channel_audio_out, 32'h00001234);
        chk("pass_right", bus.right_channel_audio_out, 32'h00005678);
        $display("txn pass L=%h R=%h", bus.left_channel_audio_out, bus.right_channel_audio_out);
        step();

        // Tone with mic also available: mic must not be popped
        bus.mode = 2'b01; bus.tone_left = 32'h11110000; bus.tone_right = 32'h2222FFFF;
        bus.tone_valid = 1'b1; bus.audio_in_available = 1'b1;
        settle();
        chk("tone_ready", {31'd0, bus.tone_ready}, 32'h1);
        chk("tone_noread", {31'd0, bus.read_audio_in}, 32'h0);
        step();
        bus.tone_valid = 1'b0; bus.audio_in_available = 1'b0;
        settle();
        chk("tone_left", bus.left_channel_audio_out, 32'h11110000);
        chk("tone_right", bus.right_channel_audio_out, 32'h2222FFFF);
        $display("txn tone L=%h R=%h", bus.left_channel_audio_out, bus.right_channel_audio_out);
        step();

        // Mix waits for both sources, then pops both together
        bus.mode = 2'b10;
        bus.left_channel_audio_in = 32'h7FFFFFFF; bus.right_channel_audio_in = 32'h80000000;
        bus.tone_left = 32'h7FFFFFFF; bus.tone_right = 32'hFFFFFFFF;
        bus.audio_in_available = 1'b1; bus.tone_valid = 1'b0;
        settle();
        chk("mix_wait_read", {31'd0, bus.read_audio_in}, 32'h0);
        step(); step();
        bus.tone_valid = 1'b1;
        settle();
        chk("mix_read", {31'd0, bus.read_audio_in}, 32'h1);
        chk("mix_tone", {31'd0, bus.tone_ready}, 32'h1);
        step();
        bus.tone_valid = 1'b0; bus.audio_in_available = 1'b0;
        settle();
`ifdef AUDIO_ARB_SAT_MIX_EN
        exp_r_mix = 32'h80000000;
`else
        exp_r_mix = 32'hBFFFFFFF;
`endif
        chk("mix_left", bus.left_channel_audio_out, 32'h7FFFFFFF);
        chk("mix_right", bus.right_channel_audio_out, exp_r_mix);
        $display("txn mix L=%h R=%h", bus.left_channel_audio_out, bus.right_channel_audio_out);
        step();

        // Backpressure: held sample stays put, mode change ignored, no pops
        bus.mode = 2'b00; bus.audio_out_allowed = 1'b0;
        bus.left_channel_audio_in = 32'hAAAA0001; bus.right_channel_audio_in = 32'h55550002;
        bus.audio_in_available = 1'b1;
        step();
        bus.mode = 2'b01; bus.tone_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("bp_nowrite", {31'd0, bus.write_audio_out}, 32'h0);
            chk("bp_noread", {31'd0, bus.read_audio_in}, 32'h0);
            chk("bp_hold", bus.left_channel_audio_out, 32'hAAAA0001);
            step();
        end
        bus.tone_valid = 1'b0; bus.audio_in_available = 1'b0; bus.audio_out_allowed = 1'b1;
        settle();
        chk("bp_write", {31'd0, bus.write_audio_out}, 32'h1);
        $display("txn backpressure L=%h R=%h", bus.left_channel_audio_out, bus.right_channel_audio_out);
        step();
        chk("bp_single", {31'd0, bus.write_audio_out}, 32'h0);

        // Reset while holding a sample discards it
        bus.mode = 2'b00; bus.audio_out_allowed = 1'b0;
        bus.left_channel_audio_in = 32'hDEAD0000; bus.audio_in_available = 1'b1;
        step();
        bus.audio_in_available = 1'b0;
        rst = 1'b1; bus.audio_out_allowed = 1'b1;
        settle();
        chk("rst_nowrite", {31'd0, bus.write_audio_out}, 32'h0);
        chk("rst_left", bus.left_channel_audio_out, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_discard", {31'd0, bus.write_audio_out}, 32'h0);
        end
        bus.mode = 2'b11; bus.left_channel_audio_in = 32'h12345678; bus.audio_in_available = 1'b1;
        settle();
        chk("mute_read", {31'd0, bus.read_audio_in}, 32'h1);
        step();
        bus.audio_in_available = 1'b0;
        settle();
        chk("mute_write", {31'd0, bus.write_audio_out}, 32'h1);
        chk("mute_left", bus.left_channel_audio_out, 32'h0);
        chk("mute_right", bus.right_channel_audio_out, 32'h0);
        $display("txn mute L=%h R=%h", bus.left_channel_audio_out, bus.right_channel_audio_out);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
